// File: rtl/mm_pkg.sv
// Shared types and constants for the MM job sequencer and its feed generator.
package mm_pkg;
  localparam int DATA_W  = 8;
  localparam int OUT_W   = 20;
  localparam int MAX_DIM = 4;
  localparam int DIM_W   = 3;

  typedef logic [DIM_W-1:0] dim_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED_A,
    S_FEED_B,
    S_WAIT_BUSY,
    S_COLLECT,
    S_DONE
  } state_t;

  function automatic logic dim_ok(input dim_t d);
    return (d != '0) && (d <= DIM_W'(MAX_DIM));
  endfunction
endpackage

// File: rtl/mm_job_ctrl_if.sv
// Link between the job sequencer and the MM core: operand stream out, results in.
interface mm_job_ctrl_if;
  import mm_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              row_end;
  logic              col_end;
  logic [OUT_W-1:0]  out_data;
  logic              is_legal;
  logic              change_row;
  logic              valid;
  logic              busy;

  modport master (
    output in_data, row_end, col_end,
    input  out_data, is_legal, change_row, valid, busy
  );

  modport slave (
    input  in_data, row_end, col_end,
    output out_data, is_legal, change_row, valid, busy
  );
endinterface

// File: rtl/mm_feed_gen.sv
// Row-major address walker for one matrix; framing flags trail the address by
// one cycle so they line up with the synchronous memory's read data.
module mm_feed_gen
  import mm_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  dim_t              rows,
  input  dim_t              cols,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  output logic              last,
  output logic              vld_d,
  output logic              row_end_d,
  output logic              col_end_d
);
  dim_t rows_q, cols_q, row, col;
  logic col_last, row_last;

  assign col_last = rd && (col == cols_q - DIM_W'(1));
  assign row_last = (row == rows_q - DIM_W'(1));
  assign last     = col_last && row_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      rd        <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
      row       <= '0;
      col       <= '0;
      vld_d     <= 1'b0;
      row_end_d <= 1'b0;
      col_end_d <= 1'b0;
    end else begin
      vld_d     <= rd;
      col_end_d <= col_last;
      row_end_d <= last;
      // go wins over the end of the current matrix so B follows A without a gap
      if (go) begin
        addr   <= base;
        rd     <= 1'b1;
        rows_q <= rows;
        cols_q <= cols;
        row    <= '0;
        col    <= '0;
      end else if (rd) begin
        if (last) begin
          rd <= 1'b0;
        end else begin
          addr <= addr + 1'b1;
          if (col_last) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/mm_job_ctrl.sv
// Job sequencer: streams A then B into MM, collects legal results, reports status.
//   state       | meaning
//   S_IDLE      | waiting for start, results/flags of last job held
//   S_FEED_A    | streaming matrix A from operand memory
//   S_FEED_B    | streaming matrix B from operand memory
//   S_WAIT_BUSY | waiting for MM to begin its compute phase
//   S_COLLECT   | writing MM results while mm busy is high
//   S_DONE      | one-cycle done pulse
module mm_job_ctrl
  import mm_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int B_BASE  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  dim_t              a_rows,
  input  dim_t              a_cols,
  input  dim_t              b_rows,
  input  dim_t              b_cols,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  mm_job_ctrl_if.master     mm,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_waddr,
  output logic [OUT_W-1:0]  res_wdata,
  output dim_t              res_rows,
  output dim_t              res_cols,
  output logic              busy,
  output logic              done,
  output logic              err_dim,
  output logic              err_illegal,
  output logic              err_timeout
);
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  state_t            state, state_nx;
  dim_t              a_rows_q, a_cols_q, b_rows_q, b_cols_q, col_cnt;
  logic [TMR_W-1:0]  tmr;
  logic [ADDR_W-1:0] wr_idx, feed_base;
  dim_t              feed_rows, feed_cols;
  logic accept, dims_ok, tmr_zero, tmr_load;
  logic feed_go, feed_sel_b, feed_rd, feed_last, feed_vld, feed_row_end, feed_col_end;

  assign accept   = (state == S_IDLE) && start;
  assign dims_ok  = dim_ok(a_rows) && dim_ok(a_cols) && dim_ok(b_rows) && dim_ok(b_cols);
  assign tmr_zero = (tmr == '0);

  assign feed_rows = feed_sel_b ? b_rows_q : a_rows_q;
  assign feed_cols = feed_sel_b ? b_cols_q : a_cols_q;
  assign feed_base = feed_sel_b ? ADDR_W'(B_BASE) : '0;

  mm_feed_gen #(.ADDR_W(ADDR_W)) u_feed (
    .clk       (clk),
    .rst       (rst),
    .go        (feed_go),
    .rows      (feed_rows),
    .cols      (feed_cols),
    .base      (feed_base),
    .addr      (mem_raddr),
    .rd        (feed_rd),
    .last      (feed_last),
    .vld_d     (feed_vld),
    .row_end_d (feed_row_end),
    .col_end_d (feed_col_end)
  );

  assign mm.in_data = feed_vld ? mem_rdata : '0;
  assign mm.row_end = feed_row_end;
  assign mm.col_end = feed_col_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (start) state_nx = dims_ok ? S_FEED_A : S_DONE;
      S_FEED_A:    if (feed_last) state_nx = S_FEED_B;
      S_FEED_B:    if (feed_last) state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (mm.busy)       state_nx = S_COLLECT;
        else if (tmr_zero) state_nx = S_DONE;
      end
      S_COLLECT:   if (!mm.busy || (tmr_zero && !mm.valid)) state_nx = S_DONE;
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // The first FEED_A cycle only arms the walker, giving the 2-cycle start latency.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    feed_go    = 1'b0;
    feed_sel_b = 1'b0;
    tmr_load   = 1'b0;
    case (state)
      S_FEED_A: begin
        busy       = 1'b1;
        feed_go    = !feed_rd || feed_last;
        feed_sel_b = feed_last;
      end
      S_FEED_B: begin
        busy     = 1'b1;
        tmr_load = feed_last;
      end
      S_WAIT_BUSY: begin
        busy     = 1'b1;
        tmr_load = mm.busy;
      end
      S_COLLECT: begin
        busy     = 1'b1;
        tmr_load = mm.valid;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rows_q    <= '0;
      a_cols_q    <= '0;
      b_rows_q    <= '0;
      b_cols_q    <= '0;
      tmr         <= '0;
      col_cnt     <= '0;
      wr_idx      <= '0;
      res_we      <= 1'b0;
      res_waddr   <= '0;
      res_wdata   <= '0;
      res_rows    <= '0;
      res_cols    <= '0;
      err_dim     <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      res_we <= 1'b0;
      if (accept) begin
        a_rows_q    <= a_rows;
        a_cols_q    <= a_cols;
        b_rows_q    <= b_rows;
        b_cols_q    <= b_cols;
        col_cnt     <= '0;
        wr_idx      <= '0;
        res_waddr   <= '0;
        res_wdata   <= '0;
        res_rows    <= '0;
        res_cols    <= '0;
        err_dim     <= !dims_ok;
        err_illegal <= 1'b0;
        err_timeout <= 1'b0;
      end

      if (tmr_load)       tmr <= TMR_W'(TIMEOUT - 1);
      else if (!tmr_zero) tmr <= tmr - 1'b1;

      if (tmr_zero && ((state == S_WAIT_BUSY && !mm.busy) ||
                       (state == S_COLLECT && mm.busy && !mm.valid)))
        err_timeout <= 1'b1;

      if (state == S_COLLECT && mm.valid) begin
        if (mm.is_legal) begin
          res_we    <= 1'b1;
          res_wdata <= mm.out_data;
          res_waddr <= wr_idx;
          wr_idx    <= wr_idx + 1'b1;
        end else begin
          err_illegal <= 1'b1;
        end
        // The row-end result itself is part of the row it closes.
        if (mm.change_row) begin
          res_rows <= res_rows + 1'b1;
          col_cnt  <= '0;
          if (res_rows == '0) res_cols <= col_cnt + dim_t'(mm.is_legal);
        end else begin
          col_cnt <= col_cnt + dim_t'(mm.is_legal);
        end
      end
    end
  end
endmodule

// File: tb/tb_mm_job_ctrl.sv
// Directed bench for mm_job_ctrl: operand memory and a behavioural MM drive the DUT.
module tb_mm_job_ctrl;
  import mm_pkg::*;

  localparam int ADDR_W  = 6;
  localparam int B_BASE  = 16;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  dim_t              a_rows = '0, a_cols = '0, b_rows = '0, b_cols = '0;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              res_we;
  logic [ADDR_W-1:0] res_waddr;
  logic [OUT_W-1:0]  res_wdata;
  dim_t              res_rows, res_cols;
  logic              busy, done, err_dim, err_illegal, err_timeout;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] wr_addr [$];
  logic [OUT_W-1:0]  wr_data [$];

  mm_job_ctrl_if mm();

  mm_job_ctrl #(.ADDR_W(ADDR_W), .B_BASE(B_BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_rows      (a_rows),
    .a_cols      (a_cols),
    .b_rows      (b_rows),
    .b_cols      (b_cols),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .mm          (mm),
    .res_we      (res_we),
    .res_waddr   (res_waddr),
    .res_wdata   (res_wdata),
    .res_rows    (res_rows),
    .res_cols    (res_cols),
    .busy        (busy),
    .done        (done),
    .err_dim     (err_dim),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (res_we) begin
      wr_addr.push_back(res_waddr);
      wr_data.push_back(res_wdata);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int ar, input int ac, input int br, input int bc);
    a_rows = dim_t'(ar);
    a_cols = dim_t'(ac);
    b_rows = dim_t'(br);
    b_cols = dim_t'(bc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_bad_dims(input int ar, input int ac, input int br, input int bc);
    int dc0;
    dc0 = done_cnt;
    pulse_start(ar, ac, br, bc);
    check_val("dim_done", 32'(done), 1);
    check_val("dim_err", 32'(err_dim), 1);
    check_val("dim_busy", 32'(busy), 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_val("dim_raddr", 32'(mem_raddr), 0);
      check_val("dim_mm_out", 32'({mm.in_data, mm.row_end, mm.col_end}), 0);
    end
    check_val("dim_done_cnt", 32'(done_cnt - dc0), 1);
  endtask

  // mode: 0 normal, 1 illegal product, 2 MM never busy, 3 stray starts, 4 reset in COLLECT
  task automatic run_job(input int ar, input int ac, input int br, input int bc, input int mode);
    int na, nb, k, kb, dc0, wq0, nres, s, r, j;
    logic [DATA_W-1:0] ed;
    logic ece, ere, legal, seen;
    logic [OUT_W-1:0] ev;
    na = ar * ac;
    nb = br * bc;
    legal = (ac == br);
    dc0 = done_cnt;
    wq0 = wr_data.size();
    pulse_start(ar, ac, br, bc);
    check_val("busy_c0", 32'(busy), 1);
    for (int c = 1; c <= na + nb + 1; c++) begin
      @(negedge clk);
      start = (mode == 3 && c == na + 3);
      if (c == 1) begin
        check_val("stream_idle", 32'(mm.in_data), 0);
      end else begin
        k = c - 2;
        if (k < na) begin
          ed  = mem[ADDR_W'(k)];
          ece = ((k % ac) == ac - 1);
          ere = (k == na - 1);
        end else begin
          kb  = k - na;
          ed  = mem[ADDR_W'(B_BASE + kb)];
          ece = ((kb % bc) == bc - 1);
          ere = (kb == nb - 1);
        end
        check_val("stream_data", 32'(mm.in_data), 32'(ed));
        check_val("stream_col_end", 32'(mm.col_end), 32'(ece));
        check_val("stream_row_end", 32'(mm.row_end), 32'(ere));
      end
    end
    start = 1'b0;

    if (mode == 2) begin
      for (int c = na + nb + 2; c <= na + nb + TIMEOUT + 1; c++) begin
        @(negedge clk);
        if (c == na + nb + TIMEOUT) begin
          check_val("tmo_early", 32'(err_timeout), 0);
          check_val("tmo_early_done", 32'(done), 0);
        end
      end
      check_val("tmo_flag", 32'(err_timeout), 1);
      check_val("tmo_done", 32'(done), 1);
      return;
    end

    @(negedge clk);
    check_val("stream_tail", 32'(mm.in_data), 0);
    mm.busy = 1'b1;
    @(negedge clk);
    nres = legal ? ar * bc : 1;
    for (int i = 0; i < nres; i++) begin
      r = legal ? i / bc : 0;
      j = legal ? i % bc : 0;
      s = 0;
      if (legal)
        for (int l = 0; l < ac; l++)
          s += int'($signed(mem[ADDR_W'(r * ac + l)])) *
               int'($signed(mem[ADDR_W'(B_BASE + l * bc + j)]));
      mm.valid      = 1'b1;
      mm.out_data   = OUT_W'(s);
      mm.is_legal   = legal;
      mm.change_row = legal && (j == bc - 1);
      @(negedge clk);
      mm.valid      = 1'b0;
      mm.out_data   = '0;
      mm.is_legal   = 1'b0;
      mm.change_row = 1'b0;
      start = (mode == 3 && i == 0);
      if (mode == 4 && i == 1) begin
        #2 rst = 1'b0;
        #1;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_res_we", 32'(res_we), 0);
        check_val("rst_res_waddr", 32'(res_waddr), 0);
        check_val("rst_res_wdata", 32'(res_wdata), 0);
        check_val("rst_res_rows", 32'(res_rows), 0);
        check_val("rst_raddr", 32'(mem_raddr), 0);
        check_val("rst_mm_out", 32'({mm.in_data, mm.row_end, mm.col_end}), 0);
        mm.busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
      start = 1'b0;
    end
    mm.busy = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    check_val("done_seen", 32'(seen), 1);
    @(negedge clk);
    check_val("done_once", 32'(done_cnt - dc0), 1);
    check_val("busy_end", 32'(busy), 0);
    check_val("err_dim", 32'(err_dim), 0);
    check_val("err_timeout", 32'(err_timeout), 0);
    check_val("err_illegal", 32'(err_illegal), 32'(!legal));
    check_val("wr_count", 32'(wr_data.size() - wq0), legal ? ar * bc : 0);
    check_val("res_rows", 32'(res_rows), legal ? ar : 0);
    check_val("res_cols", 32'(res_cols), legal ? bc : 0);
    if (legal && wr_data.size() - wq0 == ar * bc) begin
      for (int i = 0; i < ar * bc; i++) begin
        r = i / bc;
        j = i % bc;
        s = 0;
        for (int l = 0; l < ac; l++)
          s += int'($signed(mem[ADDR_W'(r * ac + l)])) *
               int'($signed(mem[ADDR_W'(B_BASE + l * bc + j)]));
        ev = OUT_W'(s);
        check_val("wr_addr", 32'(wr_addr[wq0 + i]), i);
        check_val("wr_data", 32'(wr_data[wq0 + i]), 32'(ev));
      end
    end
  endtask

  initial begin
    mm.out_data   = '0;
    mm.is_legal   = 1'b0;
    mm.change_row = 1'b0;
    mm.valid      = 1'b0;
    mm.busy       = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    for (int i = 0; i < 6; i++) begin
      mem[i]          = DATA_W'(i + 1);
      mem[B_BASE + i] = DATA_W'(i + 7);
    end

    repeat (3) @(negedge clk);
    check_val("rst_state_busy", 32'(busy), 0);
    check_val("rst_state_done", 32'(done), 0);
    check_val("rst_state_raddr", 32'(mem_raddr), 0);
    check_val("rst_state_we", 32'(res_we), 0);
    check_val("rst_state_errs", 32'({err_dim, err_illegal, err_timeout}), 0);
    check_val("rst_state_mm", 32'({mm.in_data, mm.row_end, mm.col_end}), 0);
    rst = 1'b1;
    @(negedge clk);

    run_bad_dims(5, 3, 3, 2);
    run_bad_dims(2, 3, 3, 0);
    run_job(2, 3, 3, 2, 0);
    check_val("ref_58", 32'(wr_data[0]), 58);
    check_val("ref_154", 32'(wr_data[3]), 154);
    run_job(2, 2, 3, 2, 1);
    run_job(2, 3, 3, 2, 2);
    @(negedge clk);
    run_job(2, 3, 3, 2, 3);
    run_job(2, 3, 3, 2, 4);
    mem[0]      = 8'd3;
    mem[B_BASE] = 8'hFC;
    run_job(1, 1, 1, 1, 0);
    check_val("neg_result", 32'(wr_data[wr_data.size() - 1]), 32'h000F_FFF4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
